// File: rtl/seq_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// seq_shift_add_multiplier
//   Iterative N-bit unsigned shift-add multiplier. One partial product is
//   accumulated per RUN cycle; the loop bound is decided by a not-equal
//   comparator that checks the next iteration count against N.
//
//   Optional build macro: SEQ_MUL_EARLY_TERM_EN
//     When defined, RUN also ends as soon as no set multiplier bits remain,
//     with N still acting as the upper bound. The product is unchanged.
//
// Ports
//   clk     in   1   rising-edge clock
//   rst_n   in   1   asynchronous active-low reset
//   start   in   1   request, accepted only while ready=1
//   a       in   N   multiplicand, sampled on accept
//   b       in   N   multiplier, sampled on accept
//   ready   out  1   high in IDLE
//   busy    out  1   high in RUN
//   done    out  1   one-cycle pulse when the product is updated
//   product out  2N  registered result, held until the next completion
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// seq_mul_neq_cmp
//   W-bit not-equal comparator used as the multiplier loop-continue test.
// Ports
//   lhs  in  W  first operand
//   rhs  in  W  second operand
//   neq  out 1  high when lhs != rhs
// -----------------------------------------------------------------------------
module seq_mul_neq_cmp #(
  parameter int W = 3
) (
  input  logic [W-1:0] lhs,
  input  logic [W-1:0] rhs,
  output logic         neq
);
  assign neq = (lhs != rhs);
endmodule

module seq_shift_add_multiplier #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateE;

  stateE          state;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;

  logic [CW-1:0]  cntNext;
  logic [2*N-1:0] accNext;
  logic           cntNeN;
  logic           lastIter;

  assign cntNext = cnt + CW'(1);
  assign accNext = mplier[0] ? (acc + mcand) : acc;

  seq_mul_neq_cmp #(
    .W (CW)
  ) uBoundCmp (
    .lhs (cntNext),
    .rhs (CW'(N)),
    .neq (cntNeN)
  );

`ifdef SEQ_MUL_EARLY_TERM_EN
  logic noBitsLeft;
  assign noBitsLeft = ((mplier >> 1) == '0);
  assign lastIter   = !cntNeN || noBitsLeft;
`else
  assign lastIter   = !cntNeN;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{N{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
            ready  <= 1'b0;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          acc    <= accNext;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cntNext;
          if (lastIter) begin
            // The final add lands in product directly, not via acc.
            product <= accNext;
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
module tb_seq_shift_add_multiplier;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int checks = 0;
  int errors = 0;

  logic [2*N-1:0] expQ[$];
  logic [2*N-1:0] prevProd;

  seq_shift_add_multiplier #(
    .N (N)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Expected RUN length for a given multiplier value.
  function automatic int refLen(input logic [N-1:0] bv);
    int len;
`ifdef SEQ_MUL_EARLY_TERM_EN
    len = 1;
    for (int i = 0; i < N; i++) if (bv[i]) len = i + 1;
`else
    len = N;
`endif
    return len;
  endfunction

  function automatic logic [2*N-1:0] refMul(input logic [N-1:0] av, input logic [N-1:0] bv);
    logic [2*N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (bv[i]) r = r + ({{N{1'b0}}, av} << i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted request and push its expected product.
  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    expQ.push_back(refMul(av, bv));
    tick();
    start = 1'b0;
  endtask

  // Advance until done (bounded); reports RUN cycles seen and product stability.
  task automatic waitDone(output int runCycles, output bit timedOut, output bit heldOk);
    int g;
    runCycles = 0;
    heldOk = 1'b1;
    g = 0;
    while (done !== 1'b1 && g < 200) begin
      if (busy === 1'b1) runCycles++;
      if (product !== prevProd) heldOk = 1'b0;
      tick();
      g++;
    end
    timedOut = (done !== 1'b1);
  endtask

  function automatic logic [2*N-1:0] popExp();
    logic [2*N-1:0] e;
    if (expQ.size() == 0) e = 'x;
    else e = expQ.pop_front();
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (product !== '0) begin errors++; $display("FAIL reset_product got %0d exp 0", product); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    prevProd = '0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", ready); end
  endtask

  task automatic test_basic();
    int rc; bit to, held; logic [2*N-1:0] e;
    issue(4'd13, 4'd11);
    waitDone(rc, to, held);
    e = popExp();
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got %b exp 0", to); end
    checks++; if (rc != refLen(4'd11)) begin errors++; $display("FAIL basic_runlen got %0d exp %0d", rc, refLen(4'd11)); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL basic_held got %b exp 1", held); end
    checks++; if (product !== e) begin errors++; $display("FAIL basic_product got %0d exp %0d", product, e); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL basic_ready_in_done got %b exp 0", ready); end
    prevProd = e;
    tick();
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL basic_after_done ready=%b done=%b exp 1/0", ready, done); end
    tick(); tick();
    checks++; if (product !== 8'd143) begin errors++; $display("FAIL basic_hold got %0d exp 143", product); end
  endtask

  task automatic test_zero_and_full();
    int rc; bit to, held; logic [2*N-1:0] e;
    logic [N-1:0] av[2] = '{4'd15, 4'd0};
    logic [N-1:0] bv[2] = '{4'd15, 4'd9};
    for (int k = 0; k < 2; k++) begin
      issue(av[k], bv[k]);
      waitDone(rc, to, held);
      e = popExp();
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL zf%0d_timeout got %b exp 0", k, to); end
      checks++; if (rc != refLen(bv[k])) begin errors++; $display("FAIL zf%0d_runlen got %0d exp %0d", k, rc, refLen(bv[k])); end
      checks++; if (held !== 1'b1) begin errors++; $display("FAIL zf%0d_held got %b exp 1", k, held); end
      checks++; if (product !== e) begin errors++; $display("FAIL zf%0d_product got %0d exp %0d", k, product, e); end
      prevProd = e;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int doneAt[$]; int cyc; logic [2*N-1:0] e;
    a = 4'd3; b = 4'd5; start = 1'b1;
    for (int k = 0; k < 3; k++) expQ.push_back(refMul(4'd3, 4'd5));
    tick();
    for (cyc = 0; cyc < 60; cyc++) begin
      if (done === 1'b1) begin
        doneAt.push_back(cyc);
        e = popExp();
        checks++; if (product !== e) begin errors++; $display("FAIL b2b_product got %0d exp %0d", product, e); end
        prevProd = e;
        if (doneAt.size() == 3) begin
          start = 1'b0;
          break;
        end
      end
      tick();
    end
    checks++; if (doneAt.size() != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", doneAt.size()); end
    if (doneAt.size() == 3) begin
      checks++; if (doneAt[0] != refLen(4'd5)) begin errors++; $display("FAIL b2b_first got %0d exp %0d", doneAt[0], refLen(4'd5)); end
      checks++; if (doneAt[1] - doneAt[0] != refLen(4'd5) + 2) begin errors++; $display("FAIL b2b_period1 got %0d exp %0d", doneAt[1] - doneAt[0], refLen(4'd5) + 2); end
      checks++; if (doneAt[2] - doneAt[1] != refLen(4'd5) + 2) begin errors++; $display("FAIL b2b_period2 got %0d exp %0d", doneAt[2] - doneAt[1], refLen(4'd5) + 2); end
    end
    start = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL b2b_idle busy=%b ready=%b exp 0/1", busy, ready); end
  endtask

  task automatic test_ignore_start();
    int rc; bit to, held; logic [2*N-1:0] e;
    issue(4'd7, 4'd6);
    tick();
    a = 4'd1; b = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(rc, to, held);
    e = popExp();
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL ign_timeout got %b exp 0", to); end
    checks++; if (rc != refLen(4'd6) - 2) begin errors++; $display("FAIL ign_runlen got %0d exp %0d", rc, refLen(4'd6) - 2); end
    checks++; if (product !== e) begin errors++; $display("FAIL ign_product got %0d exp %0d", product, e); end
    prevProd = e;
    tick(); tick(); tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ign_no_second busy=%b done=%b exp 0/0", busy, done); end
  endtask

  task automatic test_reset_mid_run();
    int rc; bit to, held; logic [2*N-1:0] e; int sawDone;
    issue(4'd9, 4'd9);
    tick();
    rst_n = 1'b0;
    #1;
    e = popExp();
    checks++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl ready=%b busy=%b done=%b exp 1/0/0", ready, busy, done); end
    checks++; if (product !== '0) begin errors++; $display("FAIL rst_mid_product got %0d exp 0", product); end
    prevProd = '0;
    tick(); tick();
    @(negedge clk); rst_n = 1'b1;
    sawDone = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done === 1'b1) sawDone++;
    end
    checks++; if (sawDone != 0) begin errors++; $display("FAIL rst_mid_no_done got %0d exp 0", sawDone); end
    issue(4'd2, 4'd3);
    waitDone(rc, to, held);
    e = popExp();
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL rst_new_timeout got %b exp 0", to); end
    checks++; if (product !== e) begin errors++; $display("FAIL rst_new_product got %0d exp %0d", product, e); end
    prevProd = e;
    tick();
  endtask

  task automatic test_early_term();
    int rc; bit to, held; logic [2*N-1:0] e;
    logic [N-1:0] av[3] = '{4'd13, 4'd13, 4'd15};
    logic [N-1:0] bv[3] = '{4'd1, 4'd0, 4'd8};
    for (int k = 0; k < 3; k++) begin
      issue(av[k], bv[k]);
      waitDone(rc, to, held);
      e = popExp();
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL et%0d_timeout got %b exp 0", k, to); end
      checks++; if (rc != refLen(bv[k])) begin errors++; $display("FAIL et%0d_runlen got %0d exp %0d", k, rc, refLen(bv[k])); end
      checks++; if (product !== e) begin errors++; $display("FAIL et%0d_product got %0d exp %0d", k, product, e); end
      prevProd = e;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_and_full();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_run();
    test_early_term();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
